// File: rtl/fxp_to_flp_stream.sv
// fxp_to_flp_stream
//   Streaming fixed-point to IEEE-754 single-precision converter with an
//   output FIFO. Input words land in stage 1. The float conversion is
//   combinational on the stage-1 word, and the result is written into the
//   FIFO on the next edge. Written words are grouped into frames of
//   C_GROUP_LEN, and FLP_LAST flags the final word of each frame.
//
//   Configuration macro: FLP_ZERO_FLUSH_EN
//     defined   : a zero input stores the exact +0.0 bit pattern.
//     undefined : the raw converter word is stored. The exponent of a zero
//                 word is meaningless, so qualify it with FLP_ZERO.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-high reset
//   FXP_VALID   input word valid
//   FXP_READY   stage can accept an input word
//   FXP_DATA    two's-complement fixed-point input (C_FXP_POINT frac bits)
//   FLP_VALID   FIFO head valid
//   FLP_READY   consumer accepts the head
//   FLP_DATA    float word at the FIFO head (0 when empty)
//   FLP_ZERO    head word came from a zero input
//   FLP_LAST    head word is the last of its frame
//   FIFO_LEVEL  FIFO occupancy, 0..C_FIFO_DEPTH
module fxp_to_flp_stream #(
  parameter int C_FXP_WIDTH  = 16,
  parameter int C_FXP_POINT  = 12,
  parameter int C_FLP_WIDTH  = 32,
  parameter int C_FIFO_DEPTH = 8,
  parameter int C_GROUP_LEN  = 3
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            FXP_VALID,
  output logic                            FXP_READY,
  input  logic [C_FXP_WIDTH-1:0]          FXP_DATA,
  output logic                            FLP_VALID,
  input  logic                            FLP_READY,
  output logic [C_FLP_WIDTH-1:0]          FLP_DATA,
  output logic                            FLP_ZERO,
  output logic                            FLP_LAST,
  output logic [$clog2(C_FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (C_GROUP_LEN > 1) ? $clog2(C_GROUP_LEN) : 1;
  localparam int EW = C_FLP_WIDTH + 2;

  // Same arithmetic as fixed_to_float_converter. The leading one of |x| sets
  // the exponent, and the bits below it form the left-justified mantissa.
  function automatic logic [C_FLP_WIDTH-1:0] fxp_to_flp(
    input logic signed [C_FXP_WIDTH-1:0] x
  );
    logic [C_FXP_WIDTH-1:0]    mag;
    logic [C_FXP_WIDTH-1:0]    norm;
    logic [C_FXP_WIDTH+22:0]   ext;
    logic [7:0]                expo;
    int                        lz;
    mag = x[C_FXP_WIDTH-1] ? -x : x;
    lz  = C_FXP_WIDTH;
    for (int i = 0; i < C_FXP_WIDTH; i++) begin
      if (mag[i]) lz = C_FXP_WIDTH - 1 - i;
    end
    // Shifting out the leading one leaves only the fraction bits.
    norm = mag << (lz + 1);
    ext  = {norm, 23'd0};
    expo = 8'(128 + C_FXP_WIDTH - C_FXP_POINT - 2 - lz);
    return {x[C_FXP_WIDTH-1], expo, ext[C_FXP_WIDTH+22 -: 23]};
  endfunction

  logic                          rdy_en;
  logic                          s1_valid;
  logic signed [C_FXP_WIDTH-1:0] s1_data;
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 rd_ptr;
  logic [LW-1:0]                 level;
  logic [GW-1:0]                 grp_cnt;
  logic [EW-1:0]                 mem [C_FIFO_DEPTH];

  logic                          accept;
  logic                          push;
  logic                          pop;
  logic                          s1_zero;
  logic                          s1_last;
  logic [C_FLP_WIDTH-1:0]        s1_flp;
  logic [EW-1:0]                 head;

  assign accept  = FXP_VALID & FXP_READY;
  assign push    = s1_valid;
  assign pop     = FLP_VALID & FLP_READY;
  assign s1_zero = (s1_data == '0);
  assign s1_last = (grp_cnt == GW'(C_GROUP_LEN - 1));

`ifdef FLP_ZERO_FLUSH_EN
  assign s1_flp = s1_zero ? '0 : fxp_to_flp(s1_data);
`else
  assign s1_flp = fxp_to_flp(s1_data);
`endif

  // The word held in stage 1 is counted as occupied. A write is then always
  // guaranteed a free slot, even if no pop happens on the same edge.
  assign FXP_READY = rdy_en &&
                     (({1'b0, level} + (LW+1)'(s1_valid)) < (LW+1)'(C_FIFO_DEPTH));

  assign head       = mem[rd_ptr];
  assign FLP_VALID  = (level != '0);
  assign FLP_DATA   = FLP_VALID ? head[C_FLP_WIDTH-1:0] : '0;
  assign FLP_ZERO   = FLP_VALID & head[C_FLP_WIDTH];
  assign FLP_LAST   = FLP_VALID & head[C_FLP_WIDTH+1];
  assign FIFO_LEVEL = level;

  // Control state. Ready is held low until the first edge after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      grp_cnt  <= '0;
    end else begin
      rdy_en   <= 1'b1;
      s1_valid <= accept;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        grp_cnt <= s1_last ? '0 : grp_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Stage 0 -> stage 1 capture, and stage 1 -> FIFO write.
  always_ff @(posedge CLK) begin
    if (accept) s1_data <= FXP_DATA;
    if (push)   mem[wr_ptr] <= {s1_last, s1_zero, s1_flp};
  end

endmodule
